// File: rtl/alu_arb_pkg.sv
// Shared types and helpers for the ALU request arbiter: FSM state encoding,
// default timeout and the round-robin pointer advance.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    localparam int DEFAULT_TIMEOUT = 15;

    // Priority moves to the requester just after the one that was served.
    function automatic int rr_advance(input int owner, input int num_req);
        return (owner + 1 >= num_req) ? 0 : owner + 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr,
// wrapping from NUM_REQ-1 back to 0.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_any
);

    always_comb begin
        int cand;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // rr_ptr is always below NUM_REQ, so one wrap is enough.
            cand = int'(rr_ptr) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!grant_any && req_valid[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = IDX_W'(cand);
                grant_any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one ALU between NUM_REQ requesters: round-robin accept, one-cycle
// start pulse, wait for rvalid or timeout, then return the result to the owner.
module alu_req_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int OP_W    = 3,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*OP_W-1:0]   req_op,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      alu_start,
    output logic [OP_W-1:0]           alu_op,
    output logic [DATA_W-1:0]         alu_a,
    output logic [DATA_W-1:0]         alu_b,
    input  logic                      alu_rvalid,
    input  logic [DATA_W-1:0]         alu_result,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_err,
    output logic                      busy,
    output logic [1:0]                dbg_state
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = 8;

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, owner_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_any;
    logic               expire;
    logic               rsp_hs;

    rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // Handshakes: a request transfers in the IDLE cycle where req_valid[i] and
    // req_ready[i] are both high; a response transfers on the rising edge where
    // rsp_valid[owner] and rsp_ready[owner] are both high. rsp_valid, rsp_data
    // and rsp_err hold steady until that edge; rsp_ready of other bits is ignored.
    assign expire    = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign rsp_hs    = (state_q == ST_RESP) && rsp_ready[owner_q];
    assign req_ready = (state_q == ST_IDLE) ? grant : '0;
    assign alu_start = (state_q == ST_ISSUE);
    assign rsp_valid = (state_q == ST_RESP) ? (NUM_REQ'(1) << owner_q) : '0;
    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE:  state_d = grant_any ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  state_d = (alu_rvalid || expire) ? ST_RESP : ST_WAIT;
            ST_RESP:  state_d = rsp_hs ? ST_IDLE : ST_RESP;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q <= '0;
            owner_q  <= '0;
            cnt_q    <= '0;
            alu_op   <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_any) begin
                        alu_op  <= req_op[int'(grant_idx)*OP_W +: OP_W];
                        alu_a   <= req_a[int'(grant_idx)*DATA_W +: DATA_W];
                        alu_b   <= req_b[int'(grant_idx)*DATA_W +: DATA_W];
                        owner_q <= grant_idx;
                    end
                end
                ST_ISSUE: cnt_q <= '0;
                ST_WAIT: begin
                    // A result arriving on the expiry cycle takes precedence.
                    if (alu_rvalid) begin
                        rsp_data <= alu_result;
                        rsp_err  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (expire) begin
                            rsp_data <= '0;
                            rsp_err  <= 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    if (rsp_hs) rr_ptr_q <= IDX_W'(rr_advance(int'(owner_q), NUM_REQ));
                end
                default: begin
                    rr_ptr_q <= '0;
                    owner_q  <= '0;
                    cnt_q    <= '0;
                    alu_op   <= '0;
                    alu_a    <= '0;
                    alu_b    <= '0;
                    rsp_data <= '0;
                    rsp_err  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_req_arbiter.md
# alu_req_arbiter

Shares the single ALU (operand registers plus its IDLE/LOAD/EXECUTE/MEM_WRITE controller) between NUM_REQ requesters. It accepts one operation at a time under round-robin arbitration, launches it with a one-cycle start pulse, and waits for the ALU's rvalid (or a timeout). It then returns the result to the owning requester over a valid/ready response handshake. It sits between the requester ports and the ALU top level, and is the only driver of the ALU start, opcode and operand inputs.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- DATA_W, 8: operand/result width.
- OP_W, 3: opcode width.
- TIMEOUT, 15: maximum WAIT cycles before an error response, 1..255.

- clk  in  1: clock; all logic is rising-edge.
- reset_n  in  1: asynchronous, active-low reset.
- req_valid  in  NUM_REQ: per-requester operation request.
- req_op  in  NUM_REQ*OP_W: opcodes; requester i occupies bits [i*OP_W +: OP_W].
- req_a, req_b  in  NUM_REQ*DATA_W: operands, packed the same way.
- req_ready  out  NUM_REQ: one-hot accept pulse.
- alu_start  out  1: one-cycle launch pulse to the ALU.
- alu_op  out  OP_W: registered opcode to the ALU.
- alu_a, alu_b  out  DATA_W: registered operands to the ALU.
- alu_rvalid  in  1: ALU result valid.
- alu_result  in  DATA_W: ALU result.
- rsp_valid  out  NUM_REQ: one-hot response valid.
- rsp_ready  in  NUM_REQ: per-requester response accept.
- rsp_data  out  DATA_W: returned result.
- rsp_err  out  1: response was produced by timeout.
- busy  out  1: high in any state other than IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is high, pick the winner by round-robin. The search starts at rr_ptr and wraps from NUM_REQ-1 to 0.
  - Assert req_ready[winner] combinationally for this cycle only.
  - Capture the winner's op, a and b into alu_op, alu_a and alu_b. Store owner = winner. Go to ISSUE.
  - With no req_valid, stay in IDLE.
- ISSUE:
  - alu_start = 1 for exactly this cycle.
  - Clear the timeout counter. Go to WAIT.
- WAIT:
  - On alu_rvalid, capture alu_result into rsp_data, set rsp_err = 0, go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT, set rsp_data = 0 and rsp_err = 1, then go to RESP.
  - If alu_rvalid and timeout expiry fall in the same cycle, the result wins and rsp_err = 0.
- RESP:
  - Hold rsp_valid[owner], rsp_data and rsp_err stable until rsp_ready[owner] is high.
  - On the handshake, set rr_ptr = (owner+1) mod NUM_REQ and go to IDLE.
  - rsp_ready on non-owner bits is ignored.
- alu_rvalid is ignored in IDLE, ISSUE and RESP; a late ALU result is dropped silently.
- alu_op, alu_a and alu_b keep their values until the next grant.
- A requester whose req_valid stays high after the handshake competes again. It gets round-robin priority only after every other valid requester has been served.
- Illegal state encoding: go to IDLE with all outputs at their reset values.

## Timing
- Reset values: state IDLE; rr_ptr 0; alu_start 0; alu_op, alu_a and alu_b 0; req_ready 0; rsp_valid 0; rsp_data 0; rsp_err 0; busy 0.
- Reset mid-operation returns to IDLE immediately (asynchronous). Any pending response is discarded and rsp_valid drops without a handshake.
- Accept is combinational in IDLE. Every other output is registered or decoded from state.
- Cycle numbering, with accept in cycle 0:
  - alu_start is high in cycle 1.
  - With the ALU controller, alu_rvalid arrives in cycle 4.
  - rsp_valid is high from cycle 5.
  - Earliest next accept is the cycle after the rsp handshake.
- Throughput: with immediate rsp_ready, one operation per 6 cycles.
- Timeout: the error response appears TIMEOUT+1 cycles after the ISSUE cycle.
- alu_start is never asserted outside ISSUE, so it never reaches the ALU while the ALU is busy.

## Structure
- Package alu_arb_pkg holds:
  - the state enum (2-bit: IDLE=0, ISSUE=1, WAIT=2, RESP=3);
  - the default TIMEOUT constant;
  - the function that computes the round-robin pointer advance.
- Sub-module rr_picker (combinational): inputs req_valid[NUM_REQ] and rr_ptr; outputs one-hot grant and the encoded grant index. It is instantiated once.
- The FSM, operand registers, timeout counter and response registers live in alu_req_arbiter.

## Test plan
- Single request: req 2 issues op=ADD, a=8'h05, b=8'h03, with an ALU model at latency 3. Expect req_ready[2] in cycle 0 and alu_start in cycle 1. Expect rsp_valid[2] in cycle 5 with rsp_data=8'h08 and rsp_err=0.
- All four requests held high continuously from reset. Expect grant order 0,1,2,3,0 with exactly one alu_start per operation.
- Backpressure: rsp_ready[1] held low for 10 cycles. Expect rsp_valid[1], rsp_data and rsp_err stable throughout, no new req_ready, and busy=1.
- ALU never returns rvalid, with TIMEOUT=15. Expect rsp_err=1 and rsp_data=0 exactly 16 cycles after alu_start. A stray alu_rvalid in the RESP state does not alter rsp_data.
- alu_rvalid coincides with the cycle the timeout counter reaches TIMEOUT. Expect rsp_err=0 and rsp_data equal to alu_result.
- reset_n asserted during WAIT. Expect all outputs at their reset values immediately, rr_ptr=0, and the next grant to go to the lowest-index valid requester.
